// File: rtl/axi_rd_pkg.sv
// Shared encodings for the AXI read responder: burst types, response codes,
// FSM states and the fixed beat size.
package axi_rd_pkg;

  localparam int         BEAT_BYTES = 8;
  localparam logic [2:0] BEAT_SIZE  = 3'd3;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LAT  = 2'd1,
    ST_BEAT = 2'd2
  } rd_state_t;

endpackage

// File: rtl/axi_rd_addr_gen.sv
// Combinational next-beat address and whole-burst error check.
// WRAP bursts are only legal when AXI_RD_WRAP_EN is defined.
module axi_rd_addr_gen
  import axi_rd_pkg::*;
#(
  parameter int ADDR_WIDTH = 64
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [7:0]            arlen_i,
  input  logic [2:0]            arsize_i,
  input  logic [1:0]            arburst_i,
  output logic [ADDR_WIDTH-1:0] next_addr_o,
  output logic                  burst_err_o
);

  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] wrap_addr;
  logic                  wrap_ok;

  assign incr_addr = addr_i + ADDR_WIDTH'(BEAT_BYTES);

`ifdef AXI_RD_WRAP_EN
  logic [ADDR_WIDTH-1:0] wrap_mask;

  assign wrap_ok   = (arlen_i == 8'd1) || (arlen_i == 8'd3) ||
                     (arlen_i == 8'd7) || (arlen_i == 8'd15);
  // Wrap window is (arlen+1) beats of 8 bytes; mask selects the in-window offset.
  assign wrap_mask = (ADDR_WIDTH'({arlen_i, 3'b000}) + ADDR_WIDTH'(BEAT_BYTES))
                     - ADDR_WIDTH'(1);
  assign wrap_addr = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
`else
  assign wrap_ok   = 1'b0;
  assign wrap_addr = incr_addr;
`endif

  always_comb begin
    next_addr_o = addr_i;
    case (arburst_i)
      BURST_FIXED: next_addr_o = addr_i;
      BURST_INCR:  next_addr_o = incr_addr;
      BURST_WRAP:  next_addr_o = wrap_addr;
      default:     next_addr_o = addr_i;
    endcase
  end

  assign burst_err_o = (arsize_i != BEAT_SIZE) ||
                       (arburst_i == 2'd3) ||
                       ((arburst_i == BURST_WRAP) && !wrap_ok);

endmodule

// File: rtl/axi_rd_responder.sv
// AXI4 read responder over an internal 64-bit word memory with a preload port.
// Optional WRAP burst support is enabled by defining AXI_RD_WRAP_EN.
module axi_rd_responder
  import axi_rd_pkg::*;
#(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int MEM_WORDS  = 4096,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pre_we,
  input  logic [ADDR_WIDTH-1:0] pre_addr,
  input  logic [DATA_WIDTH-1:0] pre_wdata,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  localparam int                IDX_W       = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int                WADDR_W     = ADDR_WIDTH - 3;
  localparam logic [WADDR_W-1:0] MEM_WORDS_W = WADDR_W'(MEM_WORDS);
  // 8-bit latency counter supports RD_LATENCY up to 256.
  localparam logic [7:0]        LAT_INIT    = 8'(RD_LATENCY - 1);

  rd_state_t             state_q, state_d;
  logic [7:0]            lat_q, lat_d;
  logic [7:0]            beat_q, beat_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic [1:0]            resp_q, resp_d;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
  logic [DATA_WIDTH-1:0] rd_word_q;

  logic                  ar_hs;
  logic                  r_hs;
  logic                  last_beat;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  burst_err;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [WADDR_W-1:0]    rd_widx;
  logic [WADDR_W-1:0]    pre_widx;
  logic [1:0]            beat_resp;
  logic                  unused_bits;

  axi_rd_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .addr_i      (addr_q),
    .arlen_i     (len_q),
    .arsize_i    (size_q),
    .arburst_i   (burst_q),
    .next_addr_o (next_addr),
    .burst_err_o (burst_err)
  );

  assign s_axi_arready = reset && (state_q == ST_IDLE);
  assign s_axi_rvalid  = (state_q == ST_BEAT);
  assign ar_hs         = s_axi_arvalid && s_axi_arready;
  assign r_hs          = s_axi_rvalid && s_axi_rready;
  assign last_beat     = (beat_q == len_q);

  // In BEAT the word being fetched is the following beat; in LAT it is the first.
  assign rd_addr  = (state_q == ST_BEAT) ? next_addr : addr_q;
  assign rd_widx  = rd_addr[ADDR_WIDTH-1:3];
  assign pre_widx = pre_addr[ADDR_WIDTH-1:3];

  assign beat_resp = burst_err                ? RESP_SLVERR :
                     (rd_widx >= MEM_WORDS_W) ? RESP_DECERR : RESP_OKAY;

  assign unused_bits = ^{rd_addr[2:0], pre_addr[2:0]};

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    beat_d  = beat_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    resp_d  = resp_q;
    rd_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ar_hs) begin
          id_d    = s_axi_arid;
          addr_d  = s_axi_araddr;
          len_d   = s_axi_arlen;
          size_d  = s_axi_arsize;
          burst_d = s_axi_arburst;
          lat_d   = LAT_INIT;
          beat_d  = 8'd0;
          state_d = ST_LAT;
        end
      end
      ST_LAT: begin
        if (lat_q == 8'd0) begin
          rd_en   = 1'b1;
          resp_d  = beat_resp;
          state_d = ST_BEAT;
        end else begin
          lat_d = lat_q - 8'd1;
        end
      end
      ST_BEAT: begin
        if (r_hs) begin
          if (last_beat) begin
            state_d = ST_IDLE;
          end else begin
            rd_en  = 1'b1;
            addr_d = next_addr;
            beat_d = beat_q + 8'd1;
            resp_d = beat_resp;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      lat_q   <= '0;
      beat_q  <= '0;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      resp_q  <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      beat_q  <= beat_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      resp_q  <= resp_d;
    end
  end

  // Block RAM: a same-edge preload and read of one word returns the old contents.
  always_ff @(posedge clk) begin
    if (pre_we && (pre_widx < MEM_WORDS_W)) begin
      mem[pre_widx[IDX_W-1:0]] <= pre_wdata;
    end
    if (rd_en) begin
      rd_word_q <= mem[rd_widx[IDX_W-1:0]];
    end
  end

  assign s_axi_rid   = id_q;
  assign s_axi_rresp = resp_q;
  assign s_axi_rlast = s_axi_rvalid && last_beat;
  assign s_axi_rdata = (s_axi_rvalid && (resp_q == RESP_OKAY)) ? rd_word_q : '0;

endmodule

// File: tb/tb_axi_rd_responder.sv
// Directed bench for axi_rd_responder: expected beats are queued when each AR is
// issued and popped on every R handshake.
module tb_axi_rd_responder;
  import axi_rd_pkg::*;

  localparam int ID_W = 13;
  localparam int AW   = 64;
  localparam int DW   = 64;
  localparam int MW   = 4096;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            pre_we = 1'b0;
  logic [AW-1:0]   pre_addr = '0;
  logic [DW-1:0]   pre_wdata = '0;
  logic [ID_W-1:0] arid = '0;
  logic [AW-1:0]   araddr = '0;
  logic [7:0]      arlen = '0;
  logic [2:0]      arsize = 3'd3;
  logic [1:0]      arburst = 2'd1;
  logic            arvalid = 1'b0;
  logic            s_axi_arready;
  logic [ID_W-1:0] s_axi_rid;
  logic [DW-1:0]   s_axi_rdata;
  logic [1:0]      s_axi_rresp;
  logic            s_axi_rlast;
  logic            s_axi_rvalid;
  logic            rready = 1'b0;

  always #5 clk = ~clk;

  axi_rd_responder #(
    .ID_WIDTH(ID_W), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_WORDS(MW), .RD_LATENCY(2)
  ) dut (
    .clk(clk), .reset(reset),
    .pre_we(pre_we), .pre_addr(pre_addr), .pre_wdata(pre_wdata),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_arsize(arsize), .s_axi_arburst(arburst), .s_axi_arvalid(arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(rready)
  );

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [DW-1:0]   data;
    logic [1:0]      resp;
    logic            last;
  } beat_t;

  beat_t       sb[$];
  int          compared = 0;
  int          mismatched = 0;
  logic [DW-1:0] mem_model [MW];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_we = 1'b1; pre_addr = a; pre_wdata = d;
    @(negedge clk);
    pre_we = 1'b0;
    if ((a >> 3) < MW) mem_model[a[14:3]] = d;
  endtask

  function automatic logic [AW-1:0] tb_next(input logic [AW-1:0] a, input logic [7:0] len,
                                            input logic [1:0] burst);
    logic [AW-1:0] w;
    case (burst)
      2'd0: return a;
      2'd2: begin
        w = (AW'(len) + 1) * 8;
        return (a & ~(w - 1)) | ((a + 8) & (w - 1));
      end
      default: return a + 8;
    endcase
  endfunction

  task automatic push_expected(input logic [ID_W-1:0] id, input logic [AW-1:0] addr,
                               input logic [7:0] len, input logic [2:0] size,
                               input logic [1:0] burst);
    logic [AW-1:0] a;
    logic          slv;
    logic          wrap_ok;
    beat_t         b;
    a = addr;
`ifdef AXI_RD_WRAP_EN
    wrap_ok = (len == 1) || (len == 3) || (len == 7) || (len == 15);
`else
    wrap_ok = 1'b0;
`endif
    slv = (size != 3) || (burst == 3) || ((burst == 2) && !wrap_ok);
    for (int i = 0; i <= int'(len); i++) begin
      b.id   = id;
      b.last = (i == int'(len));
      if (slv) begin
        b.resp = 2'd2; b.data = '0;
      end else if ((a >> 3) >= MW) begin
        b.resp = 2'd3; b.data = '0;
      end else begin
        b.resp = 2'd0; b.data = mem_model[a[14:3]];
      end
      sb.push_back(b);
      a = tb_next(a, len, burst);
    end
  endtask

  task automatic issue_ar(input logic [ID_W-1:0] id, input logic [AW-1:0] addr,
                          input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst);
    push_expected(id, addr, len, size, burst);
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
    arvalid = 1'b1;
    for (int k = 0; k < 50 && !s_axi_arready; k++) @(negedge clk);
    chk("ar_accept", s_axi_arready, 1);
    @(negedge clk);
    arvalid = 1'b0;
  endtask

  // Runs until n beats are accepted; pat[cyc%4] drives rready each cycle.
  task automatic collect(input int n, input logic [3:0] pat, input string tag);
    int    got;
    logic  held;
    beat_t hb, ob, eb;
    got = 0; held = 1'b0; hb = '0;
    for (int cyc = 0; cyc < 200 && got < n; cyc++) begin
      rready = pat[cyc % 4];
      ob = {s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast};
      if (arvalid) chk({tag, "_arready_busy"}, s_axi_arready, 0);
      if (held) chk({tag, "_hold"}, ob, hb);
      if (s_axi_rvalid && rready) begin
        eb = (sb.size() > 0) ? sb.pop_front() : '1;
        chk($sformatf("%s_beat%0d", tag, got), ob, eb);
        $display("beat %s #%0d rid=%0h rdata=%0h rresp=%0d rlast=%0b",
                 tag, got, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast);
        got++;
      end
      held = s_axi_rvalid && !rready;
      hb   = ob;
      @(negedge clk);
    end
    rready = 1'b0;
    chk({tag, "_count"}, got, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_rvalid", s_axi_rvalid, 0);
    chk("rst_arready", s_axi_arready, 0);
    chk("rst_rlast", s_axi_rlast, 0);
    chk("rst_rresp", s_axi_rresp, 0);
    chk("rst_rid", s_axi_rid, 0);
    chk("rst_rdata", s_axi_rdata, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_arready", s_axi_arready, 1);

    preload(64'h80, 64'hDEADBEEF_CAFEF00D);
    for (int i = 0; i < 4; i++) preload(64'h100 + 64'(i * 8), 64'h1111_0000_0000_0020 + 64'(i));
    for (int i = 0; i < 8; i++) preload(64'h200 + 64'(i * 8), 64'hA5A5_0000_0000_0000 + 64'(i));

    // Single beat with latency check
    issue_ar(13'h5, 64'h80, 8'd0, 3'd3, BURST_INCR);
    chk("single_lat0", s_axi_rvalid, 0);
    @(negedge clk);
    chk("single_lat1", s_axi_rvalid, 0);
    @(negedge clk);
    chk("single_rvalid", s_axi_rvalid, 1);
    chk("single_data", s_axi_rdata, 64'hDEADBEEF_CAFEF00D);
    chk("single_rid", s_axi_rid, 13'h5);
    chk("single_rlast", s_axi_rlast, 1);
    collect(1, 4'b1111, "single");
    chk("idle_after_single", s_axi_arready, 1);

    // INCR x4 with rready toggling
    issue_ar(13'h7, 64'h100, 8'd3, 3'd3, BURST_INCR);
    collect(4, 4'b0101, "incr4");

    // FIXED x2 repeats the same word
    issue_ar(13'h8, 64'h80, 8'd1, 3'd3, BURST_FIXED);
    collect(2, 4'b1111, "fixed2");

    // WRAP x4 from 0x118
    issue_ar(13'h9, 64'h118, 8'd3, 3'd3, BURST_WRAP);
    collect(4, 4'b1111, "wrap4");

    // Out of range and bad size
    issue_ar(13'hA, 64'(MW * 8), 8'd1, 3'd3, BURST_INCR);
    collect(2, 4'b1111, "decerr");
    issue_ar(13'hB, 64'h100, 8'd1, 3'd2, BURST_INCR);
    collect(2, 4'b1011, "slverr");

    // Reset during beat 2 of an 8-beat burst
    issue_ar(13'hC, 64'h200, 8'd7, 3'd3, BURST_INCR);
    collect(1, 4'b1111, "rst_pre");
    chk("rst_beat2_valid", s_axi_rvalid, 1);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_rvalid", s_axi_rvalid, 0);
    chk("midrst_arready", s_axi_arready, 0);
    chk("midrst_rlast", s_axi_rlast, 0);
    chk("midrst_rdata", s_axi_rdata, 0);
    sb.delete();
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_release_arready", s_axi_arready, 1);
    chk("midrst_release_rvalid", s_axi_rvalid, 0);
    issue_ar(13'hD, 64'h108, 8'd0, 3'd3, BURST_INCR);
    collect(1, 4'b1111, "after_rst");

    // Back-to-back: second AR waits for the cycle after rlast handshake
    issue_ar(13'h11, 64'h200, 8'd1, 3'd3, BURST_INCR);
    arid = 13'h12; araddr = 64'h210; arlen = 8'd0; arsize = 3'd3; arburst = BURST_INCR;
    arvalid = 1'b1;
    collect(2, 4'b1111, "b2b_first");
    chk("b2b_arready_after_last", s_axi_arready, 1);
    push_expected(13'h12, 64'h210, 8'd0, 3'd3, BURST_INCR);
    @(negedge clk);
    arvalid = 1'b0;
    chk("b2b_second_lat", s_axi_rvalid, 0);
    collect(1, 4'b1111, "b2b_second");

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
